// File: rtl/video_timing_tpg.sv
// video_timing_tpg: pixel-clock video timing generator with test pattern source.
// Optional feature macro: TPG_ANIMATE_EN (adds a frame counter that scrolls the
// grey ramp and the checkerboard once per frame).
module video_timing_tpg #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk_pix,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] video_data,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [11:0] bar_px_q, bar_px_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [1:0]  mode_q, mode_d;
  logic [23:0] solid_q, solid_d;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [23:0] video_q, video_d;
  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        fs_q, fs_d;

  logic        frame_origin;
  logic        h_wrap;
  logic        active;
  logic [7:0]  ramp;
  logic        chk_x;
  logic [23:0] bar_rgb;
  logic [23:0] pix;

`ifdef TPG_ANIMATE_EN
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  chk_sum;
`endif

  // Next-state: counters, bar counter, frame-aligned pattern select, outputs
  always_comb begin
    frame_origin = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
    h_wrap       = (h_cnt_q == H_LAST);
    active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    // Pattern settings only change at the top-left pixel so frames never tear
    mode_d  = frame_origin ? mode      : mode_q;
    solid_d = frame_origin ? solid_rgb : solid_q;

    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end

    // Bar counter tracks h_cnt; it restarts with the line
    bar_px_d  = bar_px_q + 12'd1;
    bar_idx_d = bar_idx_q;
    if (h_wrap) begin
      bar_px_d  = 12'd0;
      bar_idx_d = 3'd0;
    end else if (bar_px_q == BAR_LAST) begin
      bar_px_d  = 12'd0;
      bar_idx_d = bar_idx_q + 3'd1;
    end

`ifdef TPG_ANIMATE_EN
    frame_cnt_d = (h_wrap && (v_cnt_q == V_LAST)) ? frame_cnt_q + 8'd1 : frame_cnt_q;
    ramp        = h_cnt_q[7:0] + frame_cnt_q;
    chk_sum     = h_cnt_q[5:0] + frame_cnt_q[5:0];
    chk_x       = (chk_sum >= 6'd32);
`else
    ramp        = h_cnt_q[7:0];
    chk_x       = h_cnt_q[5];
`endif

    case (bar_idx_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase

    case (mode_d)
      2'd0:    pix = bar_rgb;
      2'd1:    pix = {ramp, ramp, ramp};
      2'd2:    pix = (chk_x ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
      default: pix = solid_d;
    endcase

    hsync_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    de_d    = active;
    video_d = active ? pix : 24'd0;
    x_d     = h_cnt_q;
    y_d     = v_cnt_q;
    fs_d    = frame_origin;
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 11'd0;
      bar_px_q  <= 12'd0;
      bar_idx_q <= 3'd0;
      mode_q    <= 2'd0;
      solid_q   <= 24'd0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      de_q      <= 1'b0;
      video_q   <= 24'd0;
      x_q       <= 12'd0;
      y_q       <= 11'd0;
      fs_q      <= 1'b0;
`ifdef TPG_ANIMATE_EN
      frame_cnt_q <= 8'd0;
`endif
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      video_q   <= video_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
`ifdef TPG_ANIMATE_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign video_data  = video_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule
